// File: rtl/gauss_window_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gauss_window_gen
//
// Upstream feeder for the 3x3 Gaussian accelerator. Takes a raster-order pixel
// stream, keeps the two previous image lines in line buffers and emits one
// complete 3x3 neighbourhood for every interior pixel. Window element k lands
// in the slot the accelerator's pixel register k+1 expects.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   in_valid   input pixel valid
//   in_ready   block can accept a pixel this cycle
//   in_data    pixel value
//   in_sof     start of frame, qualifies the same beat as in_valid
//   win_valid  output register holds a valid window
//   win_ready  consumer accepts the window
//   win_data   window, [PIX_W*k +: PIX_W] = element k, row-major,
//              k=0 top-left, k=8 bottom-right
//   win_row    centre row of the window
//   win_col    centre column of the window
//   win_last   window is the last one of the frame
// -----------------------------------------------------------------------------
module gauss_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_data,
    input  logic                 in_sof,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [9*PIX_W-1:0]   win_data,
    output logic [15:0]          win_row,
    output logic [15:0]          win_col,
    output logic                 win_last
);

    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

    generate
        if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_geometry
            $error("gauss_window_gen: IMG_WIDTH and IMG_HEIGHT must both be >= 3");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [15:0]        row_q, row_d;
    logic [15:0]        col_q, col_d;
    logic [15:0]        cur_row, cur_col;
    logic               accept;
    logic               emit;
    logic               at_line_end;
    logic               at_frame_end;

    // Line buffers: lb0 holds line r-1, lb1 holds line r-2.
    logic [PIX_W-1:0]   lb0 [IMG_WIDTH];
    logic [PIX_W-1:0]   lb1 [IMG_WIDTH];
    logic [AW-1:0]      lb_addr;
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;

    // Column shift registers per window row. Index 0 is column c-2 and
    // index 1 is column c-1; the third (newest) column is the live data
    // read from the line buffers and in_data this cycle.
    logic [PIX_W-1:0]   top_q [2];
    logic [PIX_W-1:0]   top_d [2];
    logic [PIX_W-1:0]   mid_q [2];
    logic [PIX_W-1:0]   mid_d [2];
    logic [PIX_W-1:0]   bot_q [2];
    logic [PIX_W-1:0]   bot_d [2];

    logic               win_valid_q, win_valid_d;
    logic [9*PIX_W-1:0] win_data_q,  win_data_d;
    logic [15:0]        win_row_q,   win_row_d;
    logic [15:0]        win_col_q,   win_col_d;
    logic               win_last_q,  win_last_d;

    // ------------------------------------------------------------------
    // Handshake and current pixel position
    // ------------------------------------------------------------------
    // The output register is only ever overwritten when it is empty or
    // being drained in the same cycle.
    assign in_ready = ~win_valid_q | win_ready;
    assign accept   = in_valid & in_ready;

    // A start-of-frame beat is pinned to (0,0) whatever the counters say.
    // Line-buffer contents from an aborted frame need no explicit flush:
    // by the time the new frame reaches row 2 every column of both line
    // buffers has been rewritten.
    assign cur_row = in_sof ? '0 : row_q;
    assign cur_col = in_sof ? '0 : col_q;

    assign at_line_end  = (cur_col == COL_LAST);
    assign at_frame_end = at_line_end && (cur_row == ROW_LAST);
    assign emit         = accept && (cur_row >= 16'd2) && (cur_col >= 16'd2);

    assign lb_addr = cur_col[AW-1:0];
    assign lb0_rd  = lb0[lb_addr];
    assign lb1_rd  = lb1[lb_addr];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (at_line_end) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 16'd1;
            end else begin
                col_d = cur_col + 16'd1;
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        top_d = top_q;
        mid_d = mid_q;
        bot_d = bot_q;
        if (accept) begin
            top_d[0] = top_q[1];
            top_d[1] = lb1_rd;
            mid_d[0] = mid_q[1];
            mid_d[1] = lb0_rd;
            bot_d[0] = bot_q[1];
            bot_d[1] = in_data;
        end
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_last_d  = win_last_q;
        if (emit) begin
            win_valid_d = 1'b1;
            // Element 0 (top-left) sits in the least significant slice.
            win_data_d  = {in_data,  bot_q[1], bot_q[0],
                           lb0_rd,   mid_q[1], mid_q[0],
                           lb1_rd,   top_q[1], top_q[0]};
            win_row_d   = cur_row - 16'd1;
            win_col_d   = cur_col - 16'd1;
            win_last_d  = at_frame_end;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= '0;
            col_q       <= '0;
            top_q       <= '{default: '0};
            mid_q       <= '{default: '0};
            bot_q       <= '{default: '0};
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_last_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_last_q  <= win_last_d;
        end
    end

    // Line buffers are plain RAM without reset. Read happens combinationally
    // above, so the same-cycle write shifts line r-1 down to r-2 and stores
    // the incoming pixel as the new line r-1 (read-before-write).
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[lb_addr] <= lb0_rd;
            lb0[lb_addr] <= in_data;
        end
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_gauss_window_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_gauss_window_gen
//
// Self-checking bench for gauss_window_gen. A 5x4 instance covers the ramp,
// backpressure, back-to-back, aborted-frame and reset scenarios; an 8x6
// instance takes random data with random valid/ready. Expected windows are
// computed from the stored frame pixels and compared as the consumer
// accepts each window.
// -----------------------------------------------------------------------------
module tb_gauss_window_gen;

    typedef struct {
        logic [71:0] data;
        logic [15:0] row;
        logic [15:0] col;
        logic        last;
    } win_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        win_ready;

    logic        a_in_ready, a_win_valid, a_win_last;
    logic [71:0] a_win_data;
    logic [15:0] a_win_row, a_win_col;
    logic        b_in_ready, b_win_valid, b_win_last;
    logic [71:0] b_win_data;
    logic [15:0] b_win_row, b_win_col;

    logic        sel;
    logic        o_in_ready, o_win_valid, o_win_last;
    logic [71:0] o_win_data;
    logic [15:0] o_win_row, o_win_col;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nwin     = 0;
    bit          rdy_rand = 0;
    bit          rnd_valid = 0;
    bit          lat_chk  = 0;
    logic [7:0]  pix [64];
    win_t        exp_q [$];

    always #5 clk = ~clk;

    gauss_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .PIX_W(8)) dut_a (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .win_valid (a_win_valid),
        .win_ready (win_ready),
        .win_data  (a_win_data),
        .win_row   (a_win_row),
        .win_col   (a_win_col),
        .win_last  (a_win_last)
    );

    gauss_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .PIX_W(8)) dut_b (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .win_valid (b_win_valid),
        .win_ready (win_ready),
        .win_data  (b_win_data),
        .win_row   (b_win_row),
        .win_col   (b_win_col),
        .win_last  (b_win_last)
    );

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_win_valid = sel ? b_win_valid : a_win_valid;
    assign o_win_data  = sel ? b_win_data  : a_win_data;
    assign o_win_row   = sel ? b_win_row   : a_win_row;
    assign o_win_col   = sel ? b_win_col   : a_win_col;
    assign o_win_last  = sel ? b_win_last  : a_win_last;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: every interior pixel (r,c) yields the 3x3 block of
    // the stored frame centred on (r-1,c-1), raster order of emission.
    task automatic model_frame(input int w, input int h);
        win_t e;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                for (int k = 0; k < 9; k++)
                    e.data[k*8 +: 8] = pix[(r - 2 + k / 3) * w + (c - 2 + k % 3)];
                e.row  = 16'(r - 1);
                e.col  = 16'(c - 1);
                e.last = (r == h - 1) && (c == w - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic ramp(input int n);
        for (int i = 0; i < n; i++) pix[i] = 8'(i + 1);
    endtask

    // Consumer-side scoreboard.
    always @(negedge clk) begin
        win_t e;
        if (!rst && o_win_valid && win_ready) begin
            nwin++;
            if (exp_q.size() == 0) begin
                chk("unexpected_win", {71'd0, o_win_valid}, 72'd0);
            end else begin
                e = exp_q.pop_front();
                chk("win_data", o_win_data, e.data);
                chk("win_row",  {56'd0, o_win_row}, {56'd0, e.row});
                chk("win_col",  {56'd0, o_win_col}, {56'd0, e.col});
                chk("win_last", {71'd0, o_win_last}, {71'd0, e.last});
            end
        end
    end

    // Random consumer readiness.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) win_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_pix(input logic [7:0] d, input bit sof);
        bit acc = 0;
        int n   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = o_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", {71'd0, acc}, 72'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int w, input int npix, input bit sof_first);
        for (int i = 0; i < npix; i++) begin
            if (rnd_valid) begin
                while ($urandom_range(0, 1) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_pix(pix[i], sof_first && (i == 0));
            // With a permanently ready consumer, win_valid one cycle after
            // an accept says exactly whether that pixel produced a window.
            if (lat_chk)
                chk("latency", {71'd0, o_win_valid},
                    {71'd0, ((i / w) >= 2) && ((i % w) >= 2)});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_win_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [71:0] hold_data;
        int          n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
        win_ready = 1'b1; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {71'd0, o_win_valid}, 72'd0);
        chk("rst_data",  o_win_data, 72'd0);
        chk("rst_row",   {56'd0, o_win_row}, 72'd0);
        chk("rst_col",   {56'd0, o_win_col}, 72'd0);
        chk("rst_last",  {71'd0, o_win_last}, 72'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {71'd0, o_in_ready}, 72'd1);
        @(posedge clk);
        #1;

        // Ramp, no backpressure.
        ramp(20);
        nwin = 0;
        model_frame(5, 4);
        lat_chk = 1;
        send_frame(5, 20, 1);
        lat_chk = 0;
        drain();
        chk("ramp_nwin", 72'(nwin), 72'd6);

        // Backpressure right after the first window.
        nwin = 0;
        win_ready = 1'b0;
        model_frame(5, 4);
        fork
            send_frame(5, 20, 1);
            begin
                n = 0;
                while (!o_win_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first_valid", {71'd0, o_win_valid}, 72'd1);
                hold_data = exp_q[0].data;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", {71'd0, o_in_ready}, 72'd0);
                    chk("bp_valid",    {71'd0, o_win_valid}, 72'd1);
                    chk("bp_data",     o_win_data, hold_data);
                end
                @(posedge clk);
                #1;
                win_ready = 1'b1;
            end
        join
        drain();
        chk("bp_nwin", 72'(nwin), 72'd6);

        // Back-to-back frames.
        nwin = 0;
        model_frame(5, 4);
        model_frame(5, 4);
        lat_chk = 1;
        send_frame(5, 20, 1);
        send_frame(5, 20, 1);
        lat_chk = 0;
        drain();
        chk("b2b_nwin", 72'(nwin), 72'd12);

        // Aborted frame after 8 pixels, then a full frame.
        nwin = 0;
        lat_chk = 1;
        send_frame(5, 8, 1);
        model_frame(5, 4);
        send_frame(5, 20, 1);
        lat_chk = 0;
        drain();
        chk("abort_nwin", 72'(nwin), 72'd6);

        // Reset while a window is held, then replay without in_sof.
        nwin = 0;
        win_ready = 1'b0;
        model_frame(5, 4);
        send_frame(5, 13, 1);
        chk("mid_held", {71'd0, o_win_valid}, 72'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {71'd0, o_win_valid}, 72'd0);
        chk("mid_rst_data",  o_win_data, 72'd0);
        chk("mid_rst_row",   {56'd0, o_win_row}, 72'd0);
        chk("mid_rst_col",   {56'd0, o_win_col}, 72'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        win_ready = 1'b1;
        model_frame(5, 4);
        lat_chk = 1;
        send_frame(5, 20, 0);
        lat_chk = 0;
        drain();
        chk("mid_nwin", 72'(nwin), 72'd6);

        // Random data, random valid/ready on the 8x6 instance.
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 48; i++) pix[i] = 8'($urandom);
        nwin = 0;
        model_frame(8, 6);
        rdy_rand = 1;
        rnd_valid = 1;
        send_frame(8, 48, 1);
        drain();
        rdy_rand = 0;
        rnd_valid = 0;
        win_ready = 1'b1;
        chk("rand_nwin", 72'(nwin), 72'd24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
